qeciphy_link_sequencer: RTL and testbench

Top-level link bring-up sequencer for the QECIPHY. It drives the enable inputs of the TX and RX controllers and trains TX first, then RX. It declares the link ready and, on a fatal fault, timeout or loss of ready, disables both sides for a backoff period and retries a bounded number of times. When retries are exhausted it latches a sticky link fault with a cause code until software disables it.

---
 rtl/qeciphy_pkg.sv | 23 ++
 rtl/qeciphy_link_timer.sv | 34 +++
 rtl/qeciphy_link_sequencer.sv | 131 +++++++++++++
 tb/tb_qeciphy_link_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pkg.sv
// Shared QECIPHY types: link sequencer states and link-level error codes.
package qeciphy_pkg;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        TX_TRAIN = 3'd1,
        RX_TRAIN = 3'd2,
        READY    = 3'd3,
        BACKOFF  = 3'd4,
        FAULT    = 3'd5
    } link_state_t;

    localparam logic [3:0] NO_ERROR           = 4'h0;
    localparam logic [3:0] CRC_ERROR          = 4'h1;
    localparam logic [3:0] FAW_ERROR          = 4'h2;
    localparam logic [3:0] LINK_TIMEOUT_ERROR = 4'h3;
    localparam logic [3:0] LINK_LOST_ERROR    = 4'h4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qeciphy_link_timer.sv
// Saturating up-counter with synchronous clear and an equality flag against a runtime limit.
module qeciphy_link_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             hit_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/qeciphy_link_sequencer.sv
// Link bring-up sequencer: trains TX then RX, retries with backoff, latches a sticky fault.
// DISABLED idle | TX_TRAIN tx only | RX_TRAIN both | READY link up | BACKOFF both off | FAULT sticky
module qeciphy_link_sequencer
    import qeciphy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned BACKOFF_CYCLES = 256,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             link_enable_i,
    input  logic                             tx_rdy_i,
    input  logic                             tx_fault_fatal_i,
    input  logic [3:0]                       tx_error_code_i,
    input  logic                             rx_rdy_i,
    input  logic                             rx_fault_fatal_i,
    input  logic [3:0]                       rx_error_code_i,
    output logic                             tx_enable_o,
    output logic                             rx_enable_o,
    output logic                             link_rdy_o,
    output logic                             link_fault_o,
    output logic [3:0]                       link_error_code_o,
    output logic [2:0]                       link_state_o,
    output logic [$clog2(RETRY_MAX+2)-1:0]   retry_count_o
);

    localparam int unsigned TW = $clog2(max_u(TIMEOUT_CYCLES, BACKOFF_CYCLES));
    localparam int unsigned CW = $clog2(RETRY_MAX + 2);
    localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BO_LIM    = TW'(BACKOFF_CYCLES - 1);
    localparam logic [CW-1:0] RETRY_LIM = CW'(RETRY_MAX);
    localparam logic [CW-1:0] CNT_SAT   = CW'(RETRY_MAX + 1);

    link_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    code_q, code_d;
    logic          tx_en_q, rx_en_q, rdy_q, fault_q;
    logic          timer_hit;
    logic [TW-1:0] timer_limit;
    logic          rx_fail, tx_fail, tmo, lost, fail;

    assign timer_limit = (state_q == BACKOFF) ? BO_LIM : TMO_LIM;

    qeciphy_link_timer #(.WIDTH(TW)) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (state_d != state_q),
        .limit_i (timer_limit),
        .hit_o   (timer_hit)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        code_d  = code_q;
        rx_fail = 1'b0;
        tx_fail = 1'b0;
        tmo     = 1'b0;
        lost    = 1'b0;
        case (state_q)
            DISABLED: if (link_enable_i) state_d = TX_TRAIN;
            TX_TRAIN: begin
                tx_fail = tx_fault_fatal_i;
                tmo     = timer_hit && !tx_rdy_i;
                if (tx_rdy_i) state_d = RX_TRAIN;
            end
            RX_TRAIN: begin
                rx_fail = rx_fault_fatal_i;
                tx_fail = tx_fault_fatal_i;
                tmo     = timer_hit;
                lost    = !tx_rdy_i;
                if (rx_rdy_i && tx_rdy_i) state_d = READY;
            end
            READY: begin
                rx_fail = rx_fault_fatal_i;
                tx_fail = tx_fault_fatal_i;
                lost    = !tx_rdy_i || !rx_rdy_i;
            end
            BACKOFF:  if (timer_hit) state_d = TX_TRAIN;
            FAULT:    state_d = FAULT;
            default:  state_d = DISABLED;
        endcase

        fail = rx_fail || tx_fail || tmo || lost;
        // A failure overrides any success seen in the same cycle.
        if (fail) begin
            if (rx_fail)      code_d = rx_error_code_i;
            else if (tx_fail) code_d = tx_error_code_i;
            else if (tmo)     code_d = LINK_TIMEOUT_ERROR;
            else              code_d = LINK_LOST_ERROR;
            if (count_q != CNT_SAT) count_d = count_q + 1'b1;
            state_d = (count_q < RETRY_LIM) ? BACKOFF : FAULT;
        end

        if (!link_enable_i) begin
            state_d = DISABLED;
            count_d = '0;
            code_d  = NO_ERROR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DISABLED;
            count_q <= '0;
            code_q  <= NO_ERROR;
            tx_en_q <= 1'b0;
            rx_en_q <= 1'b0;
            rdy_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            code_q  <= code_d;
            tx_en_q <= (state_d == TX_TRAIN) || (state_d == RX_TRAIN) || (state_d == READY);
            rx_en_q <= (state_d == RX_TRAIN) || (state_d == READY);
            rdy_q   <= (state_d == READY);
            fault_q <= (state_d == FAULT);
        end
    end

    assign tx_enable_o       = tx_en_q;
    assign rx_enable_o       = rx_en_q;
    assign link_rdy_o        = rdy_q;
    assign link_fault_o      = fault_q;
    assign link_error_code_o = code_q;
    assign link_state_o      = state_q;
    assign retry_count_o     = count_q;

endmodule

// File: tb/tb_qeciphy_link_sequencer.sv
// Bench for the link sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_qeciphy_link_sequencer;
    import qeciphy_pkg::*;

    localparam int T = 16;
    localparam int B = 4;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, txr, txf, rxr, rxf;
    logic [3:0] txc, rxc;
    logic       tx_en, rx_en, l_rdy, l_flt;
    logic [3:0] l_code;
    logic [2:0] l_state;
    logic [1:0] l_cnt;

    int n_vec = 0;
    int n_err = 0;

    link_state_t m_st;
    int          m_t, m_rc;
    logic [3:0]  m_code;

    always #5 clk = ~clk;

    qeciphy_link_sequencer #(
        .TIMEOUT_CYCLES(T), .BACKOFF_CYCLES(B), .RETRY_MAX(R)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .link_enable_i(en),
        .tx_rdy_i(txr), .tx_fault_fatal_i(txf), .tx_error_code_i(txc),
        .rx_rdy_i(rxr), .rx_fault_fatal_i(rxf), .rx_error_code_i(rxc),
        .tx_enable_o(tx_en), .rx_enable_o(rx_en), .link_rdy_o(l_rdy),
        .link_fault_o(l_flt), .link_error_code_o(l_code),
        .link_state_o(l_state), .retry_count_o(l_cnt)
    );

    function automatic void model_reset();
        m_st = DISABLED; m_t = 0; m_rc = 0; m_code = NO_ERROR;
    endfunction

    // One clock of the link rules, evaluated on the inputs present at the edge.
    function automatic void model_step();
        link_state_t nx;
        bit          f;
        logic [3:0]  c;
        if (!en) begin
            model_reset();
            return;
        end
        nx = m_st; f = 0; c = NO_ERROR;
        case (m_st)
            DISABLED: nx = TX_TRAIN;
            TX_TRAIN: begin
                if (txf)                      begin f = 1; c = txc; end
                else if (!txr && m_t == T-1)  begin f = 1; c = LINK_TIMEOUT_ERROR; end
                else if (txr)                 nx = RX_TRAIN;
            end
            RX_TRAIN: begin
                if (rxf)               begin f = 1; c = rxc; end
                else if (txf)          begin f = 1; c = txc; end
                else if (m_t == T-1)   begin f = 1; c = LINK_TIMEOUT_ERROR; end
                else if (!txr)         begin f = 1; c = LINK_LOST_ERROR; end
                else if (rxr)          nx = READY;
            end
            READY: begin
                if (rxf)               begin f = 1; c = rxc; end
                else if (txf)          begin f = 1; c = txc; end
                else if (!txr || !rxr) begin f = 1; c = LINK_LOST_ERROR; end
            end
            BACKOFF: if (m_t == B-1) nx = TX_TRAIN;
            default: ;
        endcase
        if (f) begin
            nx     = (m_rc < R) ? BACKOFF : FAULT;
            m_rc   = (m_rc + 1 > R + 1) ? R + 1 : m_rc + 1;
            m_code = c;
        end
        m_t  = (nx != m_st) ? 0 : m_t + 1;
        m_st = nx;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic a_tx, a_rx;
        a_tx = (m_st == TX_TRAIN) || (m_st == RX_TRAIN) || (m_st == READY);
        a_rx = (m_st == RX_TRAIN) || (m_st == READY);
        return {a_tx, a_rx, m_st == READY, m_st == FAULT, m_code, 3'(m_st), 2'(m_rc)};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {tx_en, rx_en, l_rdy, l_flt, l_code, l_state, l_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; txr = 0; txf = 0; rxr = 0; rxf = 0; txc = 4'h0; rxc = 4'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++; $display("FAIL reset: got %h expected %h", obs_vec(), 14'h0);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_happy_path();
        for (int i = 0; i < 12; i++) begin
            en = 1; txr = (i >= 3); rxr = (i >= 8);
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL happy cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_vec++;
        if (l_rdy !== 1'b1 || l_cnt !== 2'd0 || tx_en !== 1'b1 || rx_en !== 1'b1) begin
            n_err++; $display("FAIL happy_ready: rdy=%b cnt=%0d tx=%b rx=%b expected 1 0 1 1",
                              l_rdy, l_cnt, tx_en, rx_en);
        end
    endtask

    task automatic test_rx_fault_ready();
        rxf = 1; rxc = CRC_ERROR;
        tick();
        n_vec++;
        if (l_rdy !== 1'b0 || l_state !== 3'(BACKOFF) || l_code !== CRC_ERROR || l_cnt !== 2'd1) begin
            n_err++; $display("FAIL rx_fault_ready: rdy=%b st=%0d code=%0d cnt=%0d expected 0 4 1 1",
                              l_rdy, l_state, l_code, l_cnt);
        end
        rxf = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL rx_fault_recover cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_exhaustion();
        idle_inputs();
        tick();
        en = 1;
        for (int i = 1; i <= 57; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL exhaust cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 17) begin
                n_vec++;
                if (l_state !== 3'(BACKOFF) || l_code !== LINK_TIMEOUT_ERROR || l_cnt !== 2'd1 || tx_en !== 1'b0) begin
                    n_err++; $display("FAIL tx_timeout: st=%0d code=%0d cnt=%0d tx=%b expected 4 3 1 0",
                                      l_state, l_code, l_cnt, tx_en);
                end
            end
        end
        n_vec++;
        if (l_state !== 3'(FAULT) || l_flt !== 1'b1 || l_cnt !== 2'd3 || l_code !== LINK_TIMEOUT_ERROR) begin
            n_err++; $display("FAIL exhausted: st=%0d flt=%b cnt=%0d code=%0d expected 5 1 3 3",
                              l_state, l_flt, l_cnt, l_code);
        end
        txr = 1; rxr = 1;
        tick();
        n_vec++;
        if (l_state !== 3'(FAULT) || l_code !== LINK_TIMEOUT_ERROR) begin
            n_err++; $display("FAIL fault_hold: st=%0d code=%0d expected 5 3", l_state, l_code);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++; $display("FAIL disable_clear: got %h expected %h", obs_vec(), 14'h0);
        end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        tick();
        en = 1; txr = 1;
        tick();
        tick();
        n_vec++;
        if (l_state !== 3'(RX_TRAIN)) begin
            n_err++; $display("FAIL simul_setup: st=%0d expected 2", l_state);
        end
        rxr = 1; txf = 1; txc = FAW_ERROR;
        tick();
        n_vec++;
        if (l_state !== 3'(BACKOFF) || l_code !== FAW_ERROR || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL simultaneous: st=%0d code=%0d expected 4 2", l_state, l_code);
        end
        txf = 0;
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_vec++;
        if (obs_vec() !== 14'h0) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", obs_vec(), 14'h0);
        end
        #2;
        rst_n = 1;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(99) != 0);
            if ($urandom_range(9) == 0) txr = ~txr;
            if ($urandom_range(9) == 0) rxr = ~rxr;
            txf = ($urandom_range(39) == 0);
            rxf = ($urandom_range(39) == 0);
            txc = 4'($urandom);
            rxc = 4'($urandom);
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_rx_fault_ready();
        test_exhaustion();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
